// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with watchdog and sticky halt.
// Optional perf counters (cycle_cnt, instret_cnt) are built when SEQ_PERF_CNT_EN is defined.
module exec_sequencer #(
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  output logic             imem_resp_ready,
  output logic             inst_we,
  input  logic             dec_wen,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_halt,
  input  logic             dec_illegal,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  input  logic             dmem_resp_valid,
  output logic             dmem_resp_ready,
  output logic             rf_wen,
  output logic             pc_we,
  output logic             halted,
`ifdef SEQ_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic             halt_code
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_EX       = 3'd3,
    S_MEM_REQ  = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  // Last count before the watchdog would reach 2**TIMEOUT_W-1.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               next_state_s;
  logic                 abort_s;
  logic                 stall_state_s;
  logic [TIMEOUT_W-1:0] wdog_r;
  logic                 halt_code_r;
  logic                 imem_req_valid_r;
  logic                 imem_resp_ready_r;
  logic                 dmem_req_valid_r;
  logic                 dmem_resp_ready_r;
  logic                 pc_we_r;
  logic                 halted_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; a completing handshake takes priority over the watchdog.
  always_comb begin
    next_state_s  = state_r;
    abort_s       = 1'b0;
    stall_state_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        next_state_s = S_IF_REQ;
      end
      S_IF_REQ: begin
        stall_state_s = 1'b1;
        if (imem_req_ready) begin
          next_state_s = S_IF_WAIT;
        end else if (wdog_r == WDOG_LAST) begin
          next_state_s = S_HALT;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_IF_REQ;
        end
      end
      S_IF_WAIT: begin
        stall_state_s = 1'b1;
        if (imem_resp_valid) begin
          next_state_s = S_EX;
        end else if (wdog_r == WDOG_LAST) begin
          next_state_s = S_HALT;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_IF_WAIT;
        end
      end
      S_EX: begin
        if (dec_illegal || (dec_load && dec_store)) begin
          next_state_s = S_HALT;
          abort_s      = 1'b1;
        end else if (dec_halt) begin
          next_state_s = S_HALT;
        end else if (dec_load || dec_store) begin
          next_state_s = S_MEM_REQ;
        end else begin
          next_state_s = S_WB;
        end
      end
      S_MEM_REQ: begin
        stall_state_s = 1'b1;
        if (dmem_req_ready) begin
          next_state_s = S_MEM_WAIT;
        end else if (wdog_r == WDOG_LAST) begin
          next_state_s = S_HALT;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_MEM_REQ;
        end
      end
      S_MEM_WAIT: begin
        stall_state_s = 1'b1;
        if (dmem_resp_valid) begin
          next_state_s = S_WB;
        end else if (wdog_r == WDOG_LAST) begin
          next_state_s = S_HALT;
          abort_s      = 1'b1;
        end else begin
          next_state_s = S_MEM_WAIT;
        end
      end
      S_WB: begin
        next_state_s = S_IF_REQ;
      end
      S_HALT: begin
        next_state_s = S_HALT;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Watchdog: restarts on every state change, counts only while waiting on memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= {TIMEOUT_W{1'b0}};
    end else if ((next_state_s != state_r) || !stall_state_s) begin
      wdog_r <= {TIMEOUT_W{1'b0}};
    end else begin
      wdog_r <= wdog_r + WDOG_ONE;
    end
  end

  // Halt cause is captured once, on entry to HALT, and held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_code_r <= 1'b0;
    end else if ((state_r != S_HALT) && (next_state_s == S_HALT)) begin
      halt_code_r <= abort_s;
    end else begin
      halt_code_r <= halt_code_r;
    end
  end

  // Moore outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_valid_r  <= 1'b0;
      imem_resp_ready_r <= 1'b0;
      dmem_req_valid_r  <= 1'b0;
      dmem_resp_ready_r <= 1'b0;
      pc_we_r           <= 1'b0;
      halted_r          <= 1'b0;
    end else begin
      imem_req_valid_r  <= (next_state_s == S_IF_REQ);
      imem_resp_ready_r <= (next_state_s == S_IF_WAIT);
      dmem_req_valid_r  <= (next_state_s == S_MEM_REQ);
      dmem_resp_ready_r <= (next_state_s == S_MEM_WAIT);
      pc_we_r           <= (next_state_s == S_WB);
      halted_r          <= (next_state_s == S_HALT);
    end
  end

  assign imem_req_valid  = imem_req_valid_r;
  assign imem_resp_ready = imem_resp_ready_r;
  assign dmem_req_valid  = dmem_req_valid_r;
  assign dmem_resp_ready = dmem_resp_ready_r;
  assign pc_we           = pc_we_r;
  assign halted          = halted_r;
  assign halt_code       = halt_code_r;
  assign inst_we         = (state_r == S_IF_WAIT) && imem_resp_valid;
  // Stores never write rd even if the decoder reports dec_wen.
  assign rf_wen          = (state_r == S_WB) && dec_wen && !dec_store;

`ifdef SEQ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_cnt_r;
  logic [CNT_W-1:0] instret_cnt_r;

  // Free-running perf counters, wrapping naturally; cycle count freezes in HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_r   <= {CNT_W{1'b0}};
      instret_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r != S_HALT) begin
        cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (state_r == S_WB) begin
        instret_cnt_r <= instret_cnt_r + CNT_ONE;
      end else begin
        instret_cnt_r <= instret_cnt_r;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_r;
  assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed testbench for exec_sequencer (TIMEOUT_W=4); perf counter checks only with SEQ_PERF_CNT_EN.
module tb_exec_sequencer;

  localparam logic [8:0] O_IREQ  = 9'h100;
  localparam logic [8:0] O_IRESP = 9'h080;
  localparam logic [8:0] O_IWE   = 9'h040;
  localparam logic [8:0] O_DREQ  = 9'h020;
  localparam logic [8:0] O_DRESP = 9'h010;
  localparam logic [8:0] O_RFW   = 9'h008;
  localparam logic [8:0] O_PCW   = 9'h004;
  localparam logic [8:0] O_HALT  = 9'h002;
  localparam logic [8:0] O_CODE  = 9'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_ready, inst_we;
  logic dec_wen, dec_load, dec_store, dec_halt, dec_illegal;
  logic dmem_req_valid, dmem_req_ready, dmem_resp_valid, dmem_resp_ready;
  logic rf_wen, pc_we, halted, halt_code;
`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exec_sequencer #(.TIMEOUT_W(4), .CNT_W(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .inst_we         (inst_we),
    .dec_wen         (dec_wen),
    .dec_load        (dec_load),
    .dec_store       (dec_store),
    .dec_halt        (dec_halt),
    .dec_illegal     (dec_illegal),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_ready (dmem_resp_ready),
    .rf_wen          (rf_wen),
    .pc_we           (pc_we),
    .halted          (halted),
`ifdef SEQ_PERF_CNT_EN
    .cycle_cnt       (cycle_cnt),
    .instret_cnt     (instret_cnt),
`endif
    .halt_code       (halt_code)
  );

  function automatic logic [8:0] outs();
    return {imem_req_valid, imem_resp_ready, inst_we, dmem_req_valid,
            dmem_resp_ready, rf_wen, pc_we, halted, halt_code};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across an edge; on return the DUT is in its IDLE cycle.
  task automatic do_reset(input logic ireq_rdy, input logic iresp_vld,
                          input logic dreq_rdy, input logic dresp_vld);
    rst_n           = 1'b0;
    imem_req_ready  = ireq_rdy;
    imem_resp_valid = iresp_vld;
    dmem_req_ready  = dreq_rdy;
    dmem_resp_valid = dresp_vld;
    dec_wen = 1'b0; dec_load = 1'b0; dec_store = 1'b0; dec_halt = 1'b0; dec_illegal = 1'b0;
    #3;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [8:0] t1_exp [0:5];
  logic [8:0] t2_exp [0:10];

  initial begin
    t1_exp = '{9'h000, O_IREQ, O_IRESP | O_IWE, 9'h000, O_RFW | O_PCW, O_IREQ};
    t2_exp = '{9'h000, O_IREQ, O_IRESP | O_IWE, 9'h000, O_DREQ, O_DREQ, O_DREQ, O_DREQ,
               O_DRESP, O_PCW, O_IREQ};

    // Reset state
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_outs", {55'd0, outs()}, 64'd0);
`ifdef SEQ_PERF_CNT_EN
    check("reset_cycle_cnt", cycle_cnt, 64'd0);
    check("reset_instret_cnt", instret_cnt, 64'd0);
`endif

    // T1: ALU instruction, zero-wait
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    dec_wen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_alu_c%0d", i), {55'd0, outs()}, {55'd0, t1_exp[i]});
      step();
    end

    // T2: store with dmem_req_ready low for three cycles
    do_reset(1'b1, 1'b1, 1'b0, 1'b1);
    dec_wen   = 1'b1;
    dec_store = 1'b1;
    for (int i = 0; i < 11; i++) begin
      dmem_req_ready = (i >= 7);
      #1;
      check($sformatf("t2_store_c%0d", i), {55'd0, outs()}, {55'd0, t2_exp[i]});
      step();
    end

    // T3: ebreak in EX halts with code 0 and stays halted
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    dec_halt = 1'b1;
    dec_wen  = 1'b1;
    repeat (4) step();
    check("t3_halt_entry", {55'd0, outs()}, {55'd0, O_HALT});
    for (int i = 0; i < 100; i++) begin
      step();
      check("t3_halt_sticky", {55'd0, outs()}, {55'd0, O_HALT});
    end

    // Illegal has priority over ebreak -> abort code
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    dec_halt    = 1'b1;
    dec_illegal = 1'b1;
    repeat (4) step();
    check("illegal_over_halt", {55'd0, outs()}, {55'd0, O_HALT | O_CODE});

    // Load and store together is an illegal encoding
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    dec_load  = 1'b1;
    dec_store = 1'b1;
    repeat (4) step();
    check("load_and_store", {55'd0, outs()}, {55'd0, O_HALT | O_CODE});

    // T4: imem_req_ready stuck low -> abort after 15 IF_REQ cycles
    do_reset(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("t4_stall_c%0d", i), {55'd0, outs()}, {55'd0, O_IREQ});
    end
    step();
    check("t4_timeout", {55'd0, outs()}, {55'd0, O_HALT | O_CODE});

    // Handshakes in the final watchdog cycle win, and the watchdog restarts per state
    do_reset(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 15) imem_req_ready = 1'b1;
    end
    step();
    check("wdog_req_wins", {55'd0, outs()}, {55'd0, O_IRESP});
    for (int i = 17; i <= 30; i++) begin
      step();
      if (i == 30) imem_resp_valid = 1'b1;
    end
    #1;
    check("wdog_resp_wins", {55'd0, outs()}, {55'd0, O_IRESP | O_IWE});
    step();
    check("wdog_ex_after", {55'd0, outs()}, 64'd0);
    step();
    check("wdog_wb_after", {55'd0, outs()}, {55'd0, O_PCW});

    // T5: asynchronous reset during MEM_WAIT, late response ignored
    do_reset(1'b1, 1'b1, 1'b1, 1'b0);
    dec_load = 1'b1;
    dec_wen  = 1'b1;
    repeat (5) step();
    check("t5_mem_wait", {55'd0, outs()}, {55'd0, O_DRESP});
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", {55'd0, outs()}, 64'd0);
    step();
    rst_n = 1'b1;
    dmem_resp_valid = 1'b1;
    #1;
    check("t5_idle_after", {55'd0, outs()}, 64'd0);
    step();
    check("t5_if_req_after", {55'd0, outs()}, {55'd0, O_IREQ});

`ifdef SEQ_PERF_CNT_EN
    // T6: three zero-wait ALU instructions
    do_reset(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (12) step();
    check("t6_instret_12", instret_cnt, 64'd2);
    check("t6_cycle_12", cycle_cnt, 64'd12);
    step();
    check("t6_instret_13", instret_cnt, 64'd3);
    check("t6_cycle_13", cycle_cnt, 64'd13);
    // Cycle counter freezes once halted
    dec_halt = 1'b1;
    repeat (3) step();
    check("t6_halted", {63'd0, halted}, 64'd1);
    check("t6_cycle_frozen_a", cycle_cnt, 64'd16);
    repeat (5) step();
    check("t6_cycle_frozen_b", cycle_cnt, 64'd16);
    check("t6_instret_frozen", instret_cnt, 64'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
